io_uart_tx: RTL and testbench
=============================

IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868 (100 MHz / 115200 baud), meaning clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits; legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  system clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; asserted when 0.
REQ-005 SHALL have port tx_enable  input  1  when 1, draining of the core output buffer is permitted.
REQ-006 SHALL have port io_buffer_size_avai  input  32  count of bytes waiting in the core output buffer.
REQ-007 SHALL have port io_output_data  input  8  head byte of the core output buffer, valid whenever io_buffer_size_avai != 0.
REQ-008 SHALL have port io_output_en  output  1  one-cycle pop strobe to the core output buffer.
REQ-009 SHALL have port uart_txd  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-012 In IDLE, when tx_enable=1 and io_buffer_size_avai!=0, the block SHALL assert io_output_en for exactly that cycle, latch io_output_data into the shift register on the same edge, and enter START.
REQ-013 io_output_en SHALL never be high for two consecutive cycles, and SHALL never be high outside IDLE.
REQ-014 START SHALL drive uart_txd=0 for CLKS_PER_BIT cycles.
REQ-015 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, tracked by a 3-bit index that wraps from 7 to the exit of the state.
REQ-016 STOP SHALL drive uart_txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-017 From the io_output_en cycle to the first START cycle the latency SHALL be 1 clock; the line SHALL go low on the clock edge after the pop.
REQ-018 Back-to-back bytes SHALL be issued without extra idle: the IDLE cycle after STOP may pop again, so the frame period is (10 + extra bits)*CLKS_PER_BIT + 1 cycles.
REQ-019 The baud counter SHALL be 16 bits wide, count from 0 to CLKS_PER_BIT-1, and reset to 0 on every bit boundary.
REQ-020 Deasserting tx_enable mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-021 io_buffer_size_avai changing mid-frame SHALL be ignored until IDLE.

Reset
REQ-022 While reset=0, on each clk edge the FSM SHALL enter IDLE, and uart_txd=1, io_output_en=0, busy=0, counters=0, shift register=0.
REQ-023 A reset asserted mid-frame SHALL truncate the frame, with the line high on the next edge, and SHALL NOT pop a byte in that cycle.

Configuration
REQ-024 With macro IO_UART_TX_PARITY_EN defined, the PARITY state SHALL be entered after DATA and send the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-025 Without IO_UART_TX_PARITY_EN, DATA SHALL go directly to STOP and no parity logic SHALL exist.

Structure
REQ-026 The FSM state encoding typedef and the IDLE_LINE_LEVEL/START_LINE_LEVEL constants SHALL reside in shared package io_uart_pkg.
REQ-027 The baud tick generator SHALL be a sub-module io_uart_baud_tick that outputs a one-cycle tick at counter wrap and is restarted by a clear input.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-028 Scenario 1: io_buffer_size_avai=1, data=8'hA5, tx_enable=1 -> one io_output_en pulse; uart_txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy=0 afterwards.
REQ-029 Scenario 2: io_buffer_size_avai=3 held, bytes 8'h00, 8'hFF, 8'h55 -> exactly 3 pops, spaced 41 cycles apart; line levels match LSB-first framing.
REQ-030 Scenario 3: tx_enable=0 with io_buffer_size_avai=5 -> no pop and uart_txd=1 for 100 cycles; tx_enable=1 -> pop on the next cycle.
REQ-031 Scenario 4: reset=0 during the third data bit -> uart_txd=1, busy=0 on the next edge; after release with the buffer non-empty, a new frame starts with a fresh pop.
REQ-032 Scenario 5 (IO_UART_TX_PARITY_EN defined): data 8'h07 -> parity bit 1 after bit 7; data 8'h03 -> parity bit 0; frame is 11 bits.
REQ-033 Scenario 6: STOP_BITS=2, data 8'h80 -> stop high for 8 cycles; next pop no earlier than 45 cycles after the previous pop.

Source files
------------

// File: rtl/io_uart_pkg.sv
// ============================================================================
// Module      : io_uart_pkg
// Description : Shared FSM state encoding and line-level constants for the
//               io_uart transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic IDLE_LINE_LEVEL  = 1'b1;
  localparam logic START_LINE_LEVEL = 1'b0;

endpackage

`default_nettype wire

// File: rtl/io_uart_baud_tick.sv
// ============================================================================
// Module      : io_uart_baud_tick
// Description : 16-bit baud counter; one-cycle tick on the last cycle of a bit,
//               restarted from zero while clear is high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count;

  assign tick = (count == LAST_COUNT) && !clear;

  always_ff @(posedge clk) begin
    if (!reset || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/io_uart_tx.sv
// ============================================================================
// Module      : io_uart_tx
// Description : UART transmitter draining a core output buffer, 8N1/8N2 framing.
//               Optional even parity bit when IO_UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_enable,
  input  logic [31:0] io_buffer_size_avai,
  input  logic [7:0]  io_output_data,
  output logic        io_output_en,
  output logic        uart_txd,
  output logic        busy
);

  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  uart_state_t state, state_next;
  logic [7:0]  shreg, shreg_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        stop_cnt, stop_cnt_next;
  logic        pop;
  logic        tick;
  logic        baud_clear;

  // Holding the counter cleared in IDLE aligns the first START cycle to count 0
  assign baud_clear = (state == ST_IDLE);

  io_uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    bit_idx_next  = bit_idx;
    stop_cnt_next = stop_cnt;
    pop           = 1'b0;
    uart_txd      = IDLE_LINE_LEVEL;
    unique case (state)
      ST_IDLE: begin
        if (tx_enable && (io_buffer_size_avai != 32'd0)) begin
          pop        = 1'b1;
          shreg_next = io_output_data;
          state_next = ST_START;
        end
      end
      ST_START: begin
        uart_txd = START_LINE_LEVEL;
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        uart_txd = shreg[bit_idx];
        if (tick) begin
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef IO_UART_TX_PARITY_EN
      ST_PARITY: begin
        uart_txd = ^shreg;
        if (tick) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        uart_txd = IDLE_LINE_LEVEL;
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            stop_cnt_next = 1'b0;
            state_next    = ST_IDLE;
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A pop may not fire in a cycle where reset is being applied
  assign io_output_en = pop && reset;
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      bit_idx  <= bit_idx_next;
      stop_cnt <= stop_cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_io_uart_tx.sv
// ============================================================================
// Module      : tb_io_uart_tx
// Description : Directed self-checking bench for io_uart_tx (CLKS_PER_BIT=4),
//               one instance with one stop bit and one with two.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_uart_tx;

  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic        tx_enable;
  logic        sel;

  logic [31:0] avai0, avai1;
  logic [7:0]  data0, data1;
  logic        en0, en1, txd0, txd1, busy0, busy1;
  logic        txd_obs, en_obs, busy_obs;

  logic [7:0]  mem0 [16];
  logic [7:0]  mem1 [16];
  int          wr0 = 0, wr1 = 0;
  int          rd0 = 0, rd1 = 0;

  int          n_checks = 0;
  int          n_pass   = 0;

  io_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(1)) dut0 (
    .clk                (clk),
    .reset              (reset),
    .tx_enable          (tx_enable),
    .io_buffer_size_avai(avai0),
    .io_output_data     (data0),
    .io_output_en       (en0),
    .uart_txd           (txd0),
    .busy               (busy0)
  );

  io_uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(2)) dut1 (
    .clk                (clk),
    .reset              (reset),
    .tx_enable          (tx_enable),
    .io_buffer_size_avai(avai1),
    .io_output_data     (data1),
    .io_output_en       (en1),
    .uart_txd           (txd1),
    .busy               (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: bench appends at wr*, the pop strobe advances rd*
  assign avai0 = 32'(wr0 - rd0);
  assign avai1 = 32'(wr1 - rd1);
  assign data0 = mem0[rd0 % 16];
  assign data1 = mem1[rd1 % 16];

  always @(posedge clk) begin
    if (en0) rd0 <= rd0 + 1;
    if (en1) rd1 <= rd1 + 1;
  end

  assign txd_obs  = sel ? txd1  : txd0;
  assign en_obs   = sel ? en1   : en0;
  assign busy_obs = sel ? busy1 : busy0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the pop cycle; returns in the IDLE cycle that follows the frame
  task automatic expect_frame(input string tag, input logic [7:0] b, input int stops,
                              input bit drop_en);
    logic [11:0] f;
    int          nb;
    bit          seen_en, seen_idle;
    f         = '1;
    f[0]      = 1'b0;
    f[8:1]    = b;
    nb        = 10;
`ifdef IO_UART_TX_PARITY_EN
    f[9]      = ^b;
    nb        = 11;
`endif
    nb        = nb + stops - 1;
    seen_en   = 1'b0;
    seen_idle = 1'b0;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < N; c++) begin
        step();
        if (drop_en && i == 0 && c == 0) tx_enable = 1'b0;
        check($sformatf("%s_bit%0d_c%0d", tag, i, c), txd_obs, f[i]);
        seen_en   |= en_obs;
        seen_idle |= !busy_obs;
      end
    end
    check($sformatf("%s_pop_in_frame", tag), seen_en, 1'b0);
    check($sformatf("%s_busy_in_frame", tag), seen_idle, 1'b0);
    step();
    check($sformatf("%s_idle_busy", tag), busy_obs, 1'b0);
    check($sformatf("%s_idle_txd", tag), txd_obs, 1'b1);
  endtask

  initial begin
    bit bad_en, bad_txd;
    reset     = 1'b0;
    tx_enable = 1'b0;
    sel       = 1'b0;

    // Reset state, with a byte waiting and tx enabled: no pop while in reset
    step();
    mem0[0]   = 8'hA5;
    wr0       = 1;
    tx_enable = 1'b1;
    step();
    check("rst_txd", txd0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_en", en0, 1'b0);
    check("rst_txd_b", txd1, 1'b1);

    // Scenario 1: single byte A5
    reset = 1'b1;
    #1;
    check("s1_pop", en0, 1'b1);
    expect_frame("s1", 8'hA5, 1, 1'b0);
    check("s1_no_more_pop", en0, 1'b0);
    check("s1_pop_count", rd0, 1);

    // Scenario 2: three back-to-back bytes, pops 41 cycles apart
    mem0[1] = 8'h00;
    mem0[2] = 8'hFF;
    mem0[3] = 8'h55;
    wr0     = 4;
    #1;
    check("s2_pop0", en0, 1'b1);
    expect_frame("s2_00", 8'h00, 1, 1'b0);
    check("s2_pop1", en0, 1'b1);
    expect_frame("s2_ff", 8'hFF, 1, 1'b0);
    check("s2_pop2", en0, 1'b1);
    expect_frame("s2_55", 8'h55, 1, 1'b0);
    check("s2_empty", en0, 1'b0);
    check("s2_pop_count", rd0, 4);

    // Scenario 3: tx disabled with five bytes waiting
    tx_enable = 1'b0;
    mem0[4] = 8'h3C;
    mem0[5] = 8'hC3;
    mem0[6] = 8'h81;
    mem0[7] = 8'h7E;
    mem0[8] = 8'h12;
    wr0     = 9;
    bad_en  = 1'b0;
    bad_txd = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      bad_en  |= en0;
      bad_txd |= !txd0;
    end
    check("s3_no_pop", bad_en, 1'b0);
    check("s3_line_idle", bad_txd, 1'b0);
    tx_enable = 1'b1;
    #1;
    check("s3_pop", en0, 1'b1);
    expect_frame("s3_3c", 8'h3C, 1, 1'b1);
    check("s3_blocked", en0, 1'b0);
    check("s3_pop_count", rd0, 5);

    // Scenario 4: reset during the third data bit of C3
    tx_enable = 1'b1;
    #1;
    check("s4_pop", en0, 1'b1);
    for (int i = 0; i < 14; i++) step();
    check("s4_bit2", txd0, 1'b0);
    reset = 1'b0;
    step();
    check("s4_rst_txd", txd0, 1'b1);
    check("s4_rst_busy", busy0, 1'b0);
    check("s4_rst_en", en0, 1'b0);
    step();
    check("s4_rst_en2", en0, 1'b0);
    check("s4_rst_count", rd0, 6);
    reset = 1'b1;
    #1;
    check("s4_fresh_pop", en0, 1'b1);
    expect_frame("s4_81", 8'h81, 1, 1'b0);
    check("s4_pop_7e", en0, 1'b1);
    expect_frame("s4_7e", 8'h7E, 1, 1'b0);
    check("s4_pop_12", en0, 1'b1);
    expect_frame("s4_12", 8'h12, 1, 1'b0);
    check("s4_empty", en0, 1'b0);
    check("s4_pop_count", rd0, 9);

`ifdef IO_UART_TX_PARITY_EN
    // Scenario 5: even parity, 07 -> 1 and 03 -> 0
    mem0[9]  = 8'h07;
    mem0[10] = 8'h03;
    wr0      = 11;
    #1;
    check("s5_pop0", en0, 1'b1);
    expect_frame("s5_07", 8'h07, 1, 1'b0);
    check("s5_pop1", en0, 1'b1);
    expect_frame("s5_03", 8'h03, 1, 1'b0);
    check("s5_pop_count", rd0, 11);
`endif

    // Scenario 6: two stop bits, pops 45 cycles apart
    sel     = 1'b1;
    mem1[0] = 8'h80;
    mem1[1] = 8'h01;
    wr1     = 2;
    #1;
    check("s6_pop0", en1, 1'b1);
    expect_frame("s6_80", 8'h80, 2, 1'b0);
    check("s6_pop1", en1, 1'b1);
    expect_frame("s6_01", 8'h01, 2, 1'b0);
    check("s6_empty", en1, 1'b0);
    check("s6_pop_count", rd1, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
